// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM states,
// the chunk width and the nibble index counter width helper.
package nibble_serial_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width: clog2(WIDTH/NIBBLE), never below one bit.
  function automatic int cnt_width(input int width);
    int n;
    n = width / NIBBLE;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead adder: every carry is formed directly from the
// generate/propagate terms instead of rippling bit to bit.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate, lookahead carries and per-bit sum.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor. Operands are streamed one nibble
// per clock through a single cla_4bit; the carry is kept in a register
// between nibbles. Subtraction uses a + ~b + ~cin.
// Optional signed-overflow output: define NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N    = WIDTH / NIBBLE;
  localparam int IDXW = cnt_width(WIDTH);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;      // b already inverted for subtract
  logic             carry_reg, carry_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf_reg, ovf_next;
`endif

  logic [3:0] a_nib [N];
  logic [3:0] b_nib [N];
  logic [3:0] cla_a, cla_b, cla_sum;
  logic       cla_cout;

  // Slice the operand registers into nibbles for the index mux.
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign a_nib[gi] = a_reg[gi*NIBBLE +: NIBBLE];
    assign b_nib[gi] = b_reg[gi*NIBBLE +: NIBBLE];
  end

  assign cla_a = a_nib[idx_reg];
  assign cla_b = b_nib[idx_reg];

  cla_4bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_reg),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      idx_reg   <= idx_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  // Next-state logic: accept in IDLE/DONE, one nibble per RUN cycle.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    idx_next   = idx_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
        if (start) begin
          a_next     = a;
          b_next     = sub ? ~b : b;
          carry_next = cin ^ sub;
          idx_next   = '0;
          sum_next   = '0;
          cout_next  = 1'b0;
          busy_next  = 1'b1;
          state_next = RUN;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_next   = 1'b0;
`endif
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_reg == IDXW'(i)) sum_next[i*NIBBLE +: NIBBLE] = cla_sum;
        end
        carry_next = cla_cout;
        if (idx_reg == LAST) begin
          cout_next  = cla_cout;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_sum[3] != a_reg[WIDTH-1]);
`endif
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector
// table, hand-written multi-cycle sequences and randomized operations
// against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic        vsub;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mcin,
                       input logic msub, output logic [15:0] es, output logic ec,
                       output logic eo);
    logic [16:0] u;
    int sa, sb, r;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!msub) begin
      u  = {1'b0, ma} + {1'b0, mb} + 17'(mcin);
      ec = u[16];
      r  = sa + sb + int'(mcin);
    end else begin
      u  = {1'b0, ma} - {1'b0, mb} - 17'(mcin);
      ec = ~u[16];
      r  = sa - sb - int'(mcin);
    end
    es = u[15:0];
    eo = (r > 32767) || (r < -32768);
  endtask

  // One full operation with timing, result and hold checks.
  task automatic do_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                       input logic ocin, input logic osub, input logic [15:0] esum,
                       input logic ecout, input logic eovf);
    int cyc, bcnt;
    logic [15:0] got;
    @(posedge clk); #1;
    start = 1'b1; a = oa; b = ob; cin = ocin; sub = osub;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(N));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(N));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("note: unknown ovf expectation in %s", tag);
`endif
    got = sum;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum), 32'(got));
    $display("op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d", tag, oa, ob, ocin, osub, got, ecout);
  endtask

  vec_t vecs [8];

  initial begin
    int cyc, dcnt;
    logic [15:0] es, cap;
    logic ec, eo;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
            vecs[i].esum, vecs[i].ecout, vecs[i].eovf);
    end

    // start pulsed during RUN with other operands is ignored.
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b1;
    dcnt = 0; cap = '0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin dcnt++; cap = sum; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("run_start_done_count", 32'(dcnt), 32'd1);
    check("run_start_sum", 32'(cap), 32'h3333);
    $display("seq ignore_start done_count=%0d sum=%h", dcnt, cap);

    // start held high through DONE: back-to-back acceptance.
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0;
    cyc = 0;
    @(posedge clk); #1;
    while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("b2b_first_sum", 32'(sum), 32'h1010);
    a = 16'hA000; b = 16'h1000; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_after_accept", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    cyc = 1;
    while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("b2b_spacing", 32'(cyc), 32'(N + 1));
    check("b2b_second_sum", 32'(sum), 32'h9000);
    check("b2b_second_cout", 32'(cout), 32'd1);
    $display("seq back_to_back spacing=%0d sum=%h", cyc, sum);
    @(posedge clk); #1;

    // Asynchronous reset in the third RUN cycle.
    start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_partial_sum", 32'(sum), 32'h0045);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    $display("seq reset_abort cleared");
    do_op("post_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra, rb;
      logic rc, rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rc, rs, es, ec, eo);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs, es, ec, eo);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that streams operands nibble by nibble through a single `cla_4bit` instance, rippling the carry through a register between cycles. It sits directly in front of the 4-bit CLA: it slices wide operands into 4-bit chunks, feeds the CLA, and reassembles its sum/cout into a wide result. The block trades latency for area on datapaths wider than 4 bits.

## Interface
- `WIDTH`, 16, operand/result width; must be a multiple of 4 and at least 4. N = WIDTH/4.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled on rising edge
- `a`  in  WIDTH  operand A, sampled with accepted start
- `b`  in  WIDTH  operand B, sampled with accepted start
- `cin`  in  1  carry-in (borrow-in sense when sub=1), sampled with start
- `sub`  in  1  1 = subtract, sampled with start
- `busy`  out  1  high while nibbles are in flight
- `done`  out  1  one-cycle pulse; result valid
- `sum`  out  WIDTH  registered result
- `cout`  out  1  registered final carry-out
- `ovf`  out  1  signed overflow (only with `NIBBLE_SERIAL_ADDER_OVF_EN`)

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: latch a, b_eff = sub ? ~b : b, carry_reg = cin ^ sub, nibble index = 0, sum cleared to 0, then go to RUN. start is ignored in every other case.
- RUN, each edge: CLA inputs = a[4i+3:4i], b_eff[4i+3:4i], carry_reg. The CLA sum is written to sum[4i+3:4i], its cout goes to carry_reg, and i increments. After the edge that processes i = N-1, cout = the CLA cout and the state goes to DONE.
- DONE lasts one cycle, then IDLE unless start is accepted in the same cycle (back-to-back).
- start during RUN is ignored. The operand registers are not disturbed.
- Arithmetic is modulo 2^WIDTH:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: sum = a + ~b + ~cin, i.e. a − b − cin. cout=1 means no borrow.
- sum/cout hold their value after DONE until the next accepted start.
- Nibble index counter width is clog2(N), minimum 1. It never wraps past N-1.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; state IDLE; carry_reg=0.
- A reset asserted mid-RUN aborts immediately and asynchronously to the reset values. No done pulse.
- Start accepted at edge k: busy=1 after edge k. Nibble j is processed at edge k+1+j.
- done=1 and busy=0 in the cycle after edge k+N. sum/cout/ovf are valid from that cycle on.
- Throughput: one operation per N+1 cycles with back-to-back start.
- Only the CLA path is combinational. All outputs are registered.

## Configuration
- `NIBBLE_SERIAL_ADDER_OVF_EN` defined:
  - `ovf` port exists.
  - At the final RUN edge, ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (CLA sum bit 3 != a[WIDTH-1]).
  - ovf is cleared on an accepted start and held thereafter like sum.
- Undefined: no `ovf` port and no related logic.

## Structure
- `nibble_serial_adder_pkg` holds:
  - the state enum (IDLE, RUN, DONE)
  - the constant NIBBLE = 4
  - a function computing the counter width from WIDTH.
- One sub-module: an instance of the existing `cla_4bit` (ports a, b, cin, sum, cout). No other hierarchy.

## Test plan
All scenarios use WIDTH=16.
- a=00FF, b=0001, cin=0, sub=0 -> sum=0100, cout=0; done exactly 4 cycles after the start edge; busy high for 4 cycles.
- a=FFFF, b=0001, cin=0 -> sum=0000, cout=1; with macro, ovf=0. a=7FFF, b=0001 -> sum=8000, cout=0, ovf=1.
- sub=1, a=0005, b=0007, cin=0 -> sum=FFFE, cout=0. sub=1, a=0009, b=0004, cin=1 -> sum=0004, cout=1.
- start pulsed during RUN with different operands -> ignored; result is from the first operands; a single done pulse.
- start held high through DONE -> new operation accepted in the DONE cycle; next done exactly N+1 cycles after the previous done.
- rst_n dropped during the third RUN cycle -> busy/done/sum/cout go to 0 immediately. After release, a=1234, b=1111 -> sum=2345, cout=0.
